// File: rtl/axi_lite_responder.sv
// ----------------------------------------------------------------------------
// axi_lite_responder
//
// AXI4-Lite slave backed by a small word-addressed memory. It terminates the
// probe's master port and doubles as on-chip scratch RAM. One write and one
// read may be in flight at a time, and the two paths run independently. AW and
// W may arrive in either order or together. Every access is answered with
// OKAY, SLVERR or DECERR. Saturating counters track completed responses.
//
// Parameters
//   DEPTH      memory size in 32-bit words (power of two, 2..4096)
//   BASE_ADDR  byte address of word 0, aligned to 4*DEPTH
//
// Ports
//   clk, s_areset                 clock and synchronous active-high reset
//   s_axi_aw*                     write address channel (addr, size, valid/ready)
//   s_axi_w*                      write data channel (data, strb, valid/ready)
//   s_axi_b*                      write response channel (resp, valid/ready)
//   s_axi_ar*                     read address channel (addr, size, valid/ready)
//   s_axi_r*                      read data channel (data, resp, valid/ready)
//   wr_count, rd_count            completed write/read responses, saturating
// ----------------------------------------------------------------------------
module axi_lite_responder #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        s_areset,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // The window is compared in 33 bits so a window ending at the top of the
  // 32-bit space does not wrap around to zero.
  localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] ADDR_HI = ADDR_LO + 33'(4 * DEPTH);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Out-of-range is checked first, so a bad address reports DECERR even when
  // the size is also illegal.
  function automatic logic [1:0] decode_resp(input logic [31:0] addr,
                                             input logic [2:0]  size);
    if (({1'b0, addr} < ADDR_LO) || ({1'b0, addr} >= ADDR_HI)) return RESP_DECERR;
    else if (size > 3'd2) return RESP_SLVERR;
    else return RESP_OKAY;
  endfunction

  // The word index drops the byte lane bits. Any address that decodes in
  // range maps to a unique word.
  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  w_state_t    w_state, w_state_n;
  logic        aw_got, aw_got_n, w_got, w_got_n;
  logic [31:0] awaddr_q, awaddr_n, wdata_q, wdata_n;
  logic [2:0]  awsize_q, awsize_n;
  logic [3:0]  wstrb_q, wstrb_n;
  logic        awready_q, awready_n, wready_q, wready_n, bvalid_q, bvalid_n;
  logic [1:0]  bresp_q, bresp_n;
  logic [15:0] wr_count_q, wr_count_n;
  logic        aw_hs, w_hs, wr_commit;

  r_state_t    r_state, r_state_n;
  logic        arready_q, arready_n, rvalid_q, rvalid_n;
  logic [31:0] rdata_q, rdata_n;
  logic [1:0]  rresp_q, rresp_n, ar_resp;
  logic [15:0] rd_count_q, rd_count_n;
  logic        ar_hs;

  assign aw_hs = s_axi_awvalid && awready_q;
  assign w_hs  = s_axi_wvalid && wready_q;
  assign ar_hs = s_axi_arvalid && arready_q;

  // Write path next state. Each channel is latched independently. The
  // response is decoded from the merged view (this cycle's handshake or the
  // earlier latch) so AW and W landing together also finish in one edge. The
  // memory commit happens on that same edge, and only for an OKAY response.
  // Readies are computed from the next state so they can be registered.
  always_comb begin
    w_state_n  = w_state;
    aw_got_n   = aw_got;
    w_got_n    = w_got;
    awaddr_n   = awaddr_q;
    awsize_n   = awsize_q;
    wdata_n    = wdata_q;
    wstrb_n    = wstrb_q;
    bvalid_n   = bvalid_q;
    bresp_n    = bresp_q;
    wr_count_n = wr_count_q;
    wr_commit  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_got_n = 1'b1;
          awaddr_n = s_axi_awaddr;
          awsize_n = s_axi_awsize;
        end
        if (w_hs) begin
          w_got_n = 1'b1;
          wdata_n = s_axi_wdata;
          wstrb_n = s_axi_wstrb;
        end
        if (aw_got_n && w_got_n) begin
          w_state_n = W_RESP;
          bvalid_n  = 1'b1;
          bresp_n   = decode_resp(awaddr_n, awsize_n);
          wr_commit = (bresp_n == RESP_OKAY);
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_n = W_IDLE;
          aw_got_n  = 1'b0;
          w_got_n   = 1'b0;
          bvalid_n  = 1'b0;
          if (wr_count_q != 16'hFFFF) wr_count_n = wr_count_q + 16'd1;
        end
      end
      default: w_state_n = W_IDLE;
    endcase
    awready_n = (w_state_n == W_IDLE) && !aw_got_n;
    wready_n  = (w_state_n == W_IDLE) && !w_got_n;
  end

  // Read path next state. Data is taken from the array at the AR handshake
  // edge. A write committing on the same edge is not yet visible, so a
  // collision returns the old word. Error responses return zero data.
  always_comb begin
    r_state_n  = r_state;
    rvalid_n   = rvalid_q;
    rdata_n    = rdata_q;
    rresp_n    = rresp_q;
    rd_count_n = rd_count_q;
    ar_resp    = decode_resp(s_axi_araddr, s_axi_arsize);
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_n = R_DATA;
          rvalid_n  = 1'b1;
          rresp_n   = ar_resp;
          rdata_n   = (ar_resp == RESP_OKAY) ? mem[word_index(s_axi_araddr)] : 32'h0;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
          if (rd_count_q != 16'hFFFF) rd_count_n = rd_count_q + 16'd1;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
    arready_n = (r_state_n == R_IDLE);
  end

  // State and output registers for both paths. Reset clears everything except
  // the memory, and it abandons any transaction in progress.
  always_ff @(posedge clk) begin
    if (s_areset) begin
      w_state    <= W_IDLE;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      awaddr_q   <= 32'h0;
      awsize_q   <= 3'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_count_q <= 16'h0;
      r_state    <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= 2'b00;
      rd_count_q <= 16'h0;
    end else begin
      w_state    <= w_state_n;
      aw_got     <= aw_got_n;
      w_got      <= w_got_n;
      awaddr_q   <= awaddr_n;
      awsize_q   <= awsize_n;
      wdata_q    <= wdata_n;
      wstrb_q    <= wstrb_n;
      awready_q  <= awready_n;
      wready_q   <= wready_n;
      bvalid_q   <= bvalid_n;
      bresp_q    <= bresp_n;
      wr_count_q <= wr_count_n;
      r_state    <= r_state_n;
      arready_q  <= arready_n;
      rvalid_q   <= rvalid_n;
      rdata_q    <= rdata_n;
      rresp_q    <= rresp_n;
      rd_count_q <= rd_count_n;
    end
  end

  // Byte-masked memory write. Reset blocks a commit that lands on the same
  // edge. The array itself is never cleared.
  always_ff @(posedge clk) begin
    if (!s_areset && wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_n[i]) mem[word_index(awaddr_n)][8*i +: 8] <= wdata_n[8*i +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign wr_count      = wr_count_q;
  assign rd_count      = rd_count_q;

endmodule

// File: tb/tb_axi_lite_responder.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_responder
//
// Directed bench for axi_lite_responder. The responder is placed at a non-zero
// base address so that both window edges can be exercised. Inputs are driven
// and outputs sampled on the falling edge, away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_axi_lite_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LIMIT = BASE + 32'(4 * DEPTH);

  logic        clk;
  logic        s_areset;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awsize;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arsize;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic [15:0] wr_count, rd_count;

  int checks = 0;
  int errors = 0;

  axi_lite_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .s_areset(s_areset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arsize(s_axi_arsize),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a hung handshake.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Every master-side input returns to its quiet value.
  task automatic idleInputs();
    s_axi_awaddr = 32'h0; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b0;
    s_axi_wdata = 32'h0;  s_axi_wstrb = 4'h0;  s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_araddr = 32'h0; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
  endtask

  // This task presents AW and W together and releases each channel once its
  // handshake has taken place. It then counts the extra falling edges before
  // bvalid shows up and completes the B handshake.
  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] size,
                            output logic [1:0] resp, output int lat);
    logic aw_done, w_done;
    int cyc;
    s_axi_awaddr = addr; s_axi_awsize = size; s_axi_awvalid = 1'b1;
    s_axi_wdata = data;  s_axi_wstrb = strb;  s_axi_wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      logic a_hs, d_hs;
      a_hs = s_axi_awvalid && s_axi_awready;
      d_hs = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      cyc++;
      if (a_hs) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (d_hs) begin s_axi_wvalid = 1'b0; w_done = 1'b1; end
    end
    checkOutput("aw_w_accepted", 32'(aw_done && w_done), 32'h1);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    lat = 0;
    while (!s_axi_bvalid && lat < 20) begin @(negedge clk); lat++; end
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  // This task issues a read and counts the extra falling edges before rvalid
  // shows up. It then captures the data and response and completes the
  // R handshake.
  task automatic applyRead(input logic [31:0] addr, input logic [2:0] size,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
    int cyc;
    logic done;
    s_axi_araddr = addr; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      done = s_axi_arready;
      @(negedge clk);
      cyc++;
    end
    checkOutput("ar_accepted", 32'(done), 32'h1);
    s_axi_arvalid = 1'b0;
    lat = 0;
    while (!s_axi_rvalid && lat < 20) begin @(negedge clk); lat++; end
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
  endtask

  // Directed sequence. The expected values are worked out by hand from the
  // responder's behaviour, and the counters are tracked through each block.
  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;

    idleInputs();
    s_areset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", 32'(s_axi_awready), 32'h0);
    checkOutput("rst_wready",  32'(s_axi_wready),  32'h0);
    checkOutput("rst_arready", 32'(s_axi_arready), 32'h0);
    checkOutput("rst_bvalid",  32'(s_axi_bvalid),  32'h0);
    checkOutput("rst_rvalid",  32'(s_axi_rvalid),  32'h0);
    checkOutput("rst_rdata",   s_axi_rdata,        32'h0);
    checkOutput("rst_wr_count", 32'(wr_count), 32'h0);
    checkOutput("rst_rd_count", 32'(rd_count), 32'h0);
    s_areset = 1'b0;
    checkOutput("release_ready_low", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
    @(negedge clk);
    checkOutput("release_ready_high", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

    // Basic write then read of the same word.
    applyWrite(BASE + 32'h10, 32'hDEADBEEF, 4'hF, 3'd2, resp, lat);
    checkOutput("basic_bresp", 32'(resp), 32'h0);
    checkOutput("basic_b_lat", 32'(lat), 32'h0);
    applyRead(BASE + 32'h10, 3'd2, data, resp, lat);
    checkOutput("basic_rdata", data, 32'hDEADBEEF);
    checkOutput("basic_rresp", 32'(resp), 32'h0);
    checkOutput("basic_r_lat", 32'(lat), 32'h0);
    checkOutput("basic_wr_count", 32'(wr_count), 32'd1);
    checkOutput("basic_rd_count", 32'(rd_count), 32'd1);

    // W three cycles ahead of AW, with a partial strobe over a known word.
    applyWrite(BASE + 32'h20, 32'hAAAAAAAA, 4'hF, 3'd2, resp, lat);
    checkOutput("ooo_pre_bresp", 32'(resp), 32'h0);
    s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
    checkOutput("ooo_wready_before", 32'(s_axi_wready), 32'h1);
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("ooo_wait_wready_bvalid", 32'({s_axi_wready, s_axi_bvalid}), 32'h0);
      @(negedge clk);
    end
    s_axi_awaddr = BASE + 32'h20; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    checkOutput("ooo_awready", 32'(s_axi_awready), 32'h1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    checkOutput("ooo_bvalid", 32'(s_axi_bvalid), 32'h1);
    checkOutput("ooo_bresp", 32'(s_axi_bresp), 32'h0);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    applyRead(BASE + 32'h20, 3'd2, data, resp, lat);
    checkOutput("ooo_merged_word", data, 32'hAA22AA44);

    // Decode errors. Word 0 is seeded first because the out-of-range write
    // aliases onto it.
    applyWrite(BASE, 32'h0BADF00D, 4'hF, 3'd2, resp, lat);
    checkOutput("dec_seed_bresp", 32'(resp), 32'h0);
    applyWrite(LIMIT, 32'h12345678, 4'hF, 3'd2, resp, lat);
    checkOutput("dec_wr_limit_bresp", 32'(resp), 32'h3);
    applyRead(BASE, 3'd2, data, resp, lat);
    checkOutput("dec_word0_unchanged", data, 32'h0BADF00D);
    applyRead(LIMIT, 3'd2, data, resp, lat);
    checkOutput("dec_rd_limit_rresp", 32'(resp), 32'h3);
    checkOutput("dec_rd_limit_rdata", data, 32'h0);
    applyRead(BASE + 32'h10, 3'd3, data, resp, lat);
    checkOutput("slverr_rresp", 32'(resp), 32'h2);
    checkOutput("slverr_rdata", data, 32'h0);
    applyWrite(BASE + 32'h10, 32'h0, 4'hF, 3'd3, resp, lat);
    checkOutput("slverr_bresp", 32'(resp), 32'h2);
    applyRead(BASE + 32'h10, 3'd2, data, resp, lat);
    checkOutput("slverr_word_unchanged", data, 32'hDEADBEEF);
    applyRead(BASE - 32'h4, 3'd2, data, resp, lat);
    checkOutput("dec_below_base_rresp", 32'(resp), 32'h3);
    checkOutput("dec_wr_count", 32'(wr_count), 32'd6);
    checkOutput("dec_rd_count", 32'(rd_count), 32'd7);

    // Backpressure on R. A second AR stays pending until the slot frees.
    s_axi_araddr = BASE + 32'h10; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
    checkOutput("bp_arready", 32'(s_axi_arready), 32'h1);
    @(negedge clk);
    s_axi_araddr = BASE + 32'h20;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold_rvalid_arready", 32'({s_axi_rvalid, s_axi_arready}), 32'h2);
      checkOutput("bp_hold_rdata", s_axi_rdata, 32'hDEADBEEF);
      @(negedge clk);
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    checkOutput("bp_after_hs_rvalid_arready", 32'({s_axi_rvalid, s_axi_arready}), 32'h1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    checkOutput("bp_second_rvalid", 32'(s_axi_rvalid), 32'h1);
    checkOutput("bp_second_rdata", s_axi_rdata, 32'hAA22AA44);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;

    // Collision: the write commit and the AR handshake share an edge.
    applyWrite(BASE + 32'h14, 32'h1, 4'hF, 3'd2, resp, lat);
    s_axi_awaddr = BASE + 32'h14; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h2; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = BASE + 32'h14; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
    checkOutput("coll_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);
    @(negedge clk);
    idleInputs();
    checkOutput("coll_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'h3);
    checkOutput("coll_old_value", s_axi_rdata, 32'h1);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge clk);
    idleInputs();
    applyRead(BASE + 32'h14, 3'd2, data, resp, lat);
    checkOutput("coll_new_value", data, 32'h2);

    // Independent write and read to different words in parallel.
    s_axi_awaddr = BASE + 32'h18; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h66; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = BASE + 32'h20; s_axi_arsize = 3'd2; s_axi_arvalid = 1'b1;
    @(negedge clk);
    idleInputs();
    checkOutput("par_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'h3);
    checkOutput("par_rdata", s_axi_rdata, 32'hAA22AA44);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge clk);
    idleInputs();
    applyRead(BASE + 32'h18, 3'd2, data, resp, lat);
    checkOutput("par_written_word", data, 32'h66);
    checkOutput("par_wr_count", 32'(wr_count), 32'd9);
    checkOutput("par_rd_count", 32'(rd_count), 32'd13);

    // Saturation. The counters are preloaded near the top so that only a few
    // transactions are needed to reach it.
    force dut.wr_count_q = 16'hFFFC;
    force dut.rd_count_q = 16'hFFFE;
    #1;
    release dut.wr_count_q;
    release dut.rd_count_q;
    @(negedge clk);
    checkOutput("sat_preload", 32'(wr_count), 32'h0000FFFC);
    for (int i = 0; i < 3; i++) applyWrite(BASE + 32'h24, 32'(i), 4'hF, 3'd2, resp, lat);
    checkOutput("sat_wr_reach", 32'(wr_count), 32'h0000FFFF);
    for (int i = 0; i < 2; i++) applyWrite(BASE + 32'h24, 32'(i), 4'hF, 3'd2, resp, lat);
    checkOutput("sat_wr_hold", 32'(wr_count), 32'h0000FFFF);
    for (int i = 0; i < 3; i++) applyRead(BASE + 32'h24, 3'd2, data, resp, lat);
    checkOutput("sat_rd_hold", 32'(rd_count), 32'h0000FFFF);

    // Reset while a write response is stalled.
    applyWrite(BASE + 32'h1C, 32'h77, 4'hF, 3'd2, resp, lat);
    s_axi_awaddr = BASE + 32'h28; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hBB; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge clk);
    idleInputs();
    checkOutput("stall_bvalid", 32'(s_axi_bvalid), 32'h1);
    @(negedge clk);
    checkOutput("stall_bvalid_held", 32'(s_axi_bvalid), 32'h1);
    s_areset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_bvalid", 32'(s_axi_bvalid), 32'h0);
    checkOutput("midrst_counters", {wr_count, rd_count}, 32'h0);
    s_areset = 1'b0;
    checkOutput("midrst_ready_low", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
    @(negedge clk);
    checkOutput("midrst_ready_high", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h7);

    // A write whose commit edge coincides with reset must not land.
    s_axi_awaddr = BASE + 32'h1C; s_axi_awsize = 3'd2; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hEE; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_areset = 1'b1;
    @(negedge clk);
    idleInputs();
    checkOutput("rstcommit_bvalid", 32'(s_axi_bvalid), 32'h0);
    s_areset = 1'b0;
    repeat (2) @(negedge clk);
    applyRead(BASE + 32'h1C, 3'd2, data, resp, lat);
    checkOutput("rstcommit_word_kept", data, 32'h77);
    applyRead(BASE + 32'h28, 3'd2, data, resp, lat);
    checkOutput("stalled_write_committed", data, 32'hBB);
    checkOutput("post_rst_counts", {wr_count, rd_count}, 32'h00000002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
